// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M divide/remainder controller (DIV, DIVU, REM, REMU).
// Owns no adder; it borrows the shared stage-3 add/sub ALU while alu_own is high.
// Sequence: NEG_A (|dividend|), NEG_B (|divisor|), ITERS restoring iterations, FIX (sign).
//
// Ports:
//   clock, reset_n                 clock (rising edge), async active-low reset
//   start, op, dividend, divisor   issue request; sampled in IDLE only
//                                  op: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   stall                          hold result in DONE
//   flush                          squash in-flight op (priority over start/stall)
//   alu_eval_async                 combinational result of the shared ALU
//   alu_own, alu_add_or_sub,
//   alu_arg1, alu_arg2             ALU operand mux control and operands (1 = subtract)
//   busy, done, result             op in flight, result valid, quotient/remainder
module div_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] alu_eval_async,
  output logic            alu_own,
  output logic            alu_add_or_sub,
  output logic [XLEN-1:0] alu_arg1,
  output logic [XLEN-1:0] alu_arg2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(ITERS);
  localparam logic [XLEN-1:0] MinVal  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] AllOnes = {XLEN{1'b1}};

  typedef enum logic [2:0] {StIdle, StNegA, StNegB, StIter, StFix, StDone} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] a_q, a_d;      // dividend magnitude, becomes quotient
  logic [XLEN-1:0] d_q, d_d;      // divisor magnitude
  logic [XLEN-1:0] r_q, r_d;      // partial remainder
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_signed;
  logic            is_rem;
  logic [XLEN-1:0] iter_s;
  logic            borrow;
  logic            take;
  logic            fix_neg;

  always_comb begin
    is_signed = ~op_q[0];
    is_rem    = op_q[1];
    iter_s    = {r_q[XLEN-2:0], a_q[XLEN-1]};
    // Borrow of S - D from the sign bits: operands' MSBs differ -> D larger iff D[MSB].
    borrow    = (iter_s[XLEN-1] ^ d_q[XLEN-1]) ? d_q[XLEN-1] : alu_eval_async[XLEN-1];
    // A set R[MSB] means the 33-bit shifted remainder always exceeds D.
    take      = r_q[XLEN-1] | ~borrow;
    fix_neg   = is_signed & (is_rem ? dvd_q[XLEN-1] : (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]));

    state_d  = state_q;
    op_d     = op_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    a_d      = a_q;
    d_d      = d_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    alu_own        = 1'b0;
    alu_add_or_sub = 1'b0;
    alu_arg1       = '0;
    alu_arg2       = '0;
    busy           = (state_q != StIdle);
    done           = (state_q == StDone);

    case (state_q)
      StIdle: begin
        if (start) begin
          op_d  = op;
          dvd_d = dividend;
          dvs_d = divisor;
          if (divisor == '0) begin
            result_d = op[1] ? dividend : AllOnes;
            state_d  = StDone;
          end else if (!op[0] && (dividend == MinVal) && (divisor == AllOnes)) begin
            result_d = op[1] ? '0 : MinVal;
            state_d  = StDone;
          end else begin
            state_d = StNegA;
          end
        end
      end
      StNegA: begin
        alu_own        = 1'b1;
        alu_add_or_sub = is_signed & dvd_q[XLEN-1];
        alu_arg2       = dvd_q;
        a_d            = alu_eval_async;
        state_d        = StNegB;
      end
      StNegB: begin
        alu_own        = 1'b1;
        alu_add_or_sub = is_signed & dvs_q[XLEN-1];
        alu_arg2       = dvs_q;
        d_d            = alu_eval_async;
        r_d            = '0;
        cnt_d          = '0;
        state_d        = StIter;
      end
      StIter: begin
        alu_own        = 1'b1;
        alu_add_or_sub = 1'b1;
        alu_arg1       = iter_s;
        alu_arg2       = d_q;
        r_d            = take ? alu_eval_async : iter_s;
        a_d            = {a_q[XLEN-2:0], take};
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CntW'(ITERS - 1)) state_d = StFix;
      end
      StFix: begin
        alu_own        = 1'b1;
        alu_add_or_sub = fix_neg;
        alu_arg2       = is_rem ? r_q : a_q;
        result_d       = alu_eval_async;
        state_d        = StDone;
      end
      StDone: begin
        if (!stall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Squash: back to idle, result untouched.
    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      a_q      <= '0;
      d_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      a_q      <= a_d;
      d_q      <= d_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: self-checking bench for div_sequencer. Models the shared ALU and
// checks results/latency against an arithmetic RV32M reference.
module tb_div_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stall;
  logic        flush;
  logic [31:0] alu_eval_async;
  logic        alu_own;
  logic        alu_add_or_sub;
  logic [31:0] alu_arg1;
  logic [31:0] alu_arg2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_result;

  div_sequencer #(.XLEN(32), .ITERS(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .op             (op),
    .dividend       (dividend),
    .divisor        (divisor),
    .stall          (stall),
    .flush          (flush),
    .alu_eval_async (alu_eval_async),
    .alu_own        (alu_own),
    .alu_add_or_sub (alu_add_or_sub),
    .alu_arg1       (alu_arg1),
    .alu_arg2       (alu_arg2),
    .busy           (busy),
    .done           (done),
    .result         (result)
  );

  // Shared stage-3 add/sub ALU.
  assign alu_eval_async = alu_add_or_sub ? (alu_arg1 - alu_arg2) : (alu_arg1 + alu_arg2);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RV32M semantics: truncating division, remainder takes the dividend's sign.
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return o[1] ? 32'd0 : 32'h8000_0000;
    if (o[0]) return o[1] ? (a % b) : (a / b);
    sa = a;
    sb = b;
    return o[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  // Issue one op, wait for done, check latency and result.
  // hold > 0: keep stall high for hold cycles at DONE. dup: second start while busy.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input bit dup);
    logic [31:0] exp;
    int          exp_lat;
    int          cycles;
    bit          got;
    exp     = ref_div(o, a, b);
    exp_lat = is_special(o, a, b) ? 1 : 36;
    @(negedge clock);
    stall    = (hold > 0);
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    cycles   = 0;
    got      = 1'b0;
    while (!got && cycles < 100) begin
      @(negedge clock);
      cycles++;
      start = 1'b0;
      got   = done;
      if (!got && cycles == 5 && dup) begin
        start    = 1'b1;
        op       = 2'b01;
        dividend = ~a;
        divisor  = 32'd1;
      end
      if (cycles == 20 && exp_lat == 36) check({tag, "_alu_own_iter"}, {31'd0, alu_own}, 32'd1);
    end
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
    check({tag, "_result"}, result, exp);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clock);
        check({tag, "_hold_done"}, {31'd0, done}, 32'd1);
        check({tag, "_hold_result"}, result, exp);
      end
      stall = 1'b0;
    end
    @(negedge clock);
    check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    last_result = exp;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          seen_done;

    reset_n     = 1'b0;
    start       = 1'b0;
    op          = 2'b00;
    dividend    = '0;
    divisor     = '0;
    stall       = 1'b0;
    flush       = 1'b0;
    last_result = '0;
    repeat (3) @(negedge clock);
    check("rst_ctrl", {28'd0, busy, done, alu_own, alu_add_or_sub}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_arg1", alu_arg1, 32'd0);
    check("rst_arg2", alu_arg2, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Directed cases.
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 0, 1'b0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 0, 1'b0);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
    run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    run_op("divu_min_max", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("div_5_0", 2'b00, 32'd5, 32'd0, 0, 1'b0);
    run_op("rem_5_0", 2'b10, 32'd5, 32'd0, 0, 1'b0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    check("idle_alu_args", alu_arg1 | alu_arg2, 32'd0);

    // Stall at DONE, and a second start while busy.
    run_op("stall4", 2'b00, 32'd1000, 32'hFFFF_FFF9, 4, 1'b0);
    run_op("dup_start", 2'b01, 32'd12345, 32'd17, 0, 1'b1);

    // Flush at ITER cycle 10.
    @(negedge clock);
    start    = 1'b1;
    op       = 2'b01;
    dividend = 32'd100;
    divisor  = 32'd7;
    repeat (12) begin
      @(negedge clock);
      start = 1'b0;
    end
    check("flush_pre_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush_idle", {30'd0, busy, done}, 32'd0);
    check("flush_result", result, last_result);
    seen_done = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) seen_done++;
    end
    check("flush_no_done", 32'(seen_done), 32'd0);

    // Async reset mid-ITER.
    @(negedge clock);
    start    = 1'b1;
    op       = 2'b01;
    dividend = 32'd1000;
    divisor  = 32'd3;
    repeat (15) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("arst_ctrl", {29'd0, busy, done, alu_own}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 0, 1'b0);

    // Randomised ops against the reference.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = $urandom;
        1: rb = $urandom_range(1, 100);
        2: rb = -($urandom_range(1, 100));
        3: rb = 32'd0;
        default: begin
          ra = $urandom_range(0, 5000);
          rb = $urandom_range(1, 40);
        end
      endcase
      run_op("rand", ro, ra, rb, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle RV32M divide/remainder controller (DIV, DIVU, REM, REMU) in stage 3.
- It owns no adder. It borrows the shared stage-3 add/sub ALU and drives its add_or_sub, arg1 and arg2 through the stage-3 operand mux while alu_own=1.
- It sequences operand negation, 32 restoring-division iterations and result sign fix-up.
- It holds the pipeline via busy until the result is delivered.

Parameters:
XLEN, 32, operand/result width (word); only 32 is supported.
ITERS, 32, number of division iterations; must equal XLEN.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  issue a divide op; sampled in IDLE only
op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
dividend  in  XLEN  rs1 value, sampled with start
divisor  in  XLEN  rs2 value, sampled with start
stall  in  1  downstream stall; holds result in DONE
flush  in  1  squash the in-flight op
alu_eval_async  in  XLEN  combinational ALU result
alu_own  out  1  1 = stage-3 ALU operand mux selects this block
alu_add_or_sub  out  1  1 = subtract
alu_arg1  out  XLEN  ALU operand 1
alu_arg2  out  XLEN  ALU operand 2
busy  out  1  op in flight; stalls upstream stages
done  out  1  result valid
result  out  XLEN  quotient or remainder

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy, done, alu_own, alu_add_or_sub = 0; result, alu_arg1, alu_arg2, internal registers = 0.
- States: IDLE, NEG_A, NEG_B, ITER, FIX, DONE.
- busy=1 in every state except IDLE.
- alu_own=1 in NEG_A, NEG_B, ITER and FIX only.
- In IDLE, alu_* outputs = 0.

IDLE:
- start=1 latches op, dividend, divisor.
- Special cases go to DONE on the next edge:
  - divisor==0: quotient=all ones, remainder=dividend.
  - Signed op with dividend=0x8000_0000 and divisor=0xFFFF_FFFF: quotient=0x8000_0000, remainder=0.
- All other ops go to NEG_A.

NEG_A (1 cycle):
- Signed op with negative dividend: ALU computes 0 - dividend (arg1=0, arg2=dividend, sub).
- Otherwise: ALU computes 0 + dividend.
- Latch alu_eval_async as the magnitude A.

NEG_B (1 cycle):
- Same as NEG_A, applied to the divisor; latch magnitude D.
- Clear the remainder R and the counter.

ITER (exactly ITERS cycles, counter 0..31):
- S = {R[30:0], A[31]}; drive arg1=S, arg2=D, sub.
- Unsigned borrow = (S[31]^D[31]) ? D[31] : alu_eval_async[31].
- Take = R[31] | ~borrow.
- If Take: R = alu_eval_async, else R = S.
- A shifts left with Take as the new bit 0; A holds the quotient after the last iteration.
- Counter==31 goes to FIX.

FIX (1 cycle):
- Selected value: A for DIV/DIVU, R for REM/REMU.
- Negation needed:
  - DIV: sign(dividend)^sign(divisor).
  - REM: sign(dividend).
  - Unsigned ops: never.
- If negation needed, ALU computes 0 - value, else 0 + value.
- result = alu_eval_async; go to DONE.

DONE:
- done=1, result stable.
- stall=1: remain in DONE.
- stall=0: go to IDLE on the next edge; done falls with it.

Latency and control:
- Normal path: start edge to done = 36 cycles.
- Special-case path: done one cycle after start.
- start while not in IDLE is ignored.
- flush=1 in any state: next edge goes to IDLE; done is not asserted; result is unchanged.
- flush has priority over start and over stall.
- reset_n low mid-operation aborts immediately to reset values.

Test Plan:
- DIVU 100/7 -> done exactly 36 cycles after start, result=14; REMU 100/7 -> result=2.
- DIV -7/2 (0xFFFF_FFF9, 2) -> result 0xFFFF_FFFD (-3); REM -7/2 -> result 0xFFFF_FFFF (-1); REM 7/-2 -> result 1.
- DIVU 0xFFFF_FFFF/1 -> result 0xFFFF_FFFF; DIVU 0x8000_0000/0xFFFF_FFFF -> result 0 (checks the R[31]/borrow path).
- DIV 5/0 -> done after 1 cycle, result 0xFFFF_FFFF; REM 5/0 -> 5; DIV 0x8000_0000/-1 -> 0x8000_0000; REM of the same -> 0.
- Hold and abort:
  - stall=1 for 4 cycles at DONE -> done and result held, then IDLE.
  - flush at ITER cycle 10 -> IDLE next edge, done never asserted.
  - Second start while busy -> ignored.
- Async reset asserted mid-ITER -> busy, done, alu_own = 0 immediately; a fresh DIVU 9/3 afterwards -> result=3.
